// File: rtl/timer_sched_pkg.sv
// Shared constants, state encodings and CTRL word builder for timer_sched.
// Optional build macro: TIMER_SCHED_READBACK_EN adds a CMP readback check.
package timer_sched_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PRESC_W    = 3;
  localparam int unsigned REG_ADDR_W = 12;

  localparam logic [REG_ADDR_W-1:0] TIMER_ADDR = 12'h0;
  localparam logic [REG_ADDR_W-1:0] CTRL_ADDR  = 12'h4;
  localparam logic [REG_ADDR_W-1:0] CMP_ADDR   = 12'h8;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_PRESC_LSB = 3;
  localparam int unsigned CTRL_PRESC_MSB = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WR_DIS,
    ST_WR_CMP,
`ifdef TIMER_SCHED_READBACK_EN
    ST_RD_CMP,
`endif
    ST_WR_CLR,
    ST_WR_EN,
    ST_WAIT,
    ST_WR_OFF,
    ST_DONE
  } state_e;

  // Each register access is: gap (bus idle), setup, access.
  typedef enum logic [1:0] {
    PH_GAP    = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_e;

  // CTRL = {26'd0, presc, 2'd0, en}
  function automatic logic [DATA_W-1:0] ctrl_word(input logic [PRESC_W-1:0] presc,
                                                  input logic en);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc;
    w[CTRL_EN_BIT] = en;
    return w;
  endfunction

endpackage

// File: rtl/timer_sched_rr_arb.sv
// Round-robin one-hot arbiter: first set request at or after ptr wins.
module timer_sched_rr_arb
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Rotating priority search starting at ptr
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = IDX_W'((int'(ptr) + i) % int'(NUM_REQ));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Shares one APB timer among NUM_REQ delay requesters (round-robin).
// Optional build macro: TIMER_SCHED_READBACK_EN reads CMP back after writing it.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_cmp,
  input  logic [NUM_REQ*PRESC_W-1:0]  req_presc,
  output logic [NUM_REQ-1:0]          done,
  output logic                        done_err,
  output logic                        busy,
  output logic [APB_ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_W-1:0]           PWDATA,
  output logic                        PWRITE,
  output logic                        PSEL,
  output logic                        PENABLE,
  input  logic [DATA_W-1:0]           PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR,
  input  logic [1:0]                  irq_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e              state;
  phase_e              phase;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    win_q;
  logic [DATA_W-1:0]   cmp_q;
  logic [PRESC_W-1:0]  presc_q;
  logic                err_q;

  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      grant_idx_c;
  logic [DATA_W-1:0]     win_cmp_c;
  logic [PRESC_W-1:0]    win_presc_c;
  logic [REG_ADDR_W-1:0] xfer_addr_c;
  logic [DATA_W-1:0]     xfer_data_c;
  logic                  xfer_write_c;
  logic                  xfer_fail_c;
  state_e                xfer_next_c;

`ifndef TIMER_SCHED_READBACK_EN
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;
`endif

  timer_sched_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant_c)
  );

  // One-hot grant to index
  always_comb begin
    grant_idx_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_c[i]) grant_idx_c = IDX_W'(i);
    end
  end

  // Select the winning requester's compare value and prescaler
  always_comb begin
    win_cmp_c   = '0;
    win_presc_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_q == IDX_W'(i)) begin
        win_cmp_c   = req_cmp[i*DATA_W +: DATA_W];
        win_presc_c = req_presc[i*PRESC_W +: PRESC_W];
      end
    end
  end

  // Per-state APB transfer contents, successor and abort condition
  always_comb begin
    xfer_addr_c  = CTRL_ADDR;
    xfer_data_c  = ctrl_word(presc_q, 1'b0);
    xfer_write_c = 1'b1;
    xfer_fail_c  = PSLVERR;
    xfer_next_c  = ST_WR_OFF;
    case (state)
      ST_WR_DIS: xfer_next_c = ST_WR_CMP;
      ST_WR_CMP: begin
        xfer_addr_c = CMP_ADDR;
        xfer_data_c = cmp_q;
`ifdef TIMER_SCHED_READBACK_EN
        xfer_next_c = ST_RD_CMP;
`else
        xfer_next_c = ST_WR_CLR;
`endif
      end
`ifdef TIMER_SCHED_READBACK_EN
      ST_RD_CMP: begin
        xfer_addr_c  = CMP_ADDR;
        xfer_data_c  = '0;
        xfer_write_c = 1'b0;
        xfer_fail_c  = PSLVERR | (PRDATA != cmp_q);
        xfer_next_c  = ST_WR_CLR;
      end
`endif
      ST_WR_CLR: begin
        xfer_addr_c = TIMER_ADDR;
        xfer_data_c = '0;
        xfer_next_c = ST_WR_EN;
      end
      ST_WR_EN: begin
        xfer_data_c = ctrl_word(presc_q, 1'b1);
        xfer_next_c = ST_WAIT;
      end
      ST_WR_OFF: begin
        xfer_fail_c = 1'b0;
        xfer_next_c = ST_DONE;
      end
      default: ;
    endcase
  end

  // Scheduler FSM with registered requester and APB outputs
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state     <= ST_IDLE;
      phase     <= PH_GAP;
      ptr_q     <= '0;
      win_q     <= '0;
      cmp_q     <= '0;
      presc_q   <= '0;
      err_q     <= 1'b0;
      req_ready <= '0;
      done      <= '0;
      done_err  <= 1'b0;
      busy      <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            state     <= ST_GRANT;
            req_ready <= grant_c;
            win_q     <= grant_idx_c;
            busy      <= 1'b1;
          end
        end

        ST_GRANT: begin
          req_ready <= '0;
          if (req_valid[win_q]) begin
            cmp_q   <= win_cmp_c;
            presc_q <= win_presc_c;
            err_q   <= 1'b0;
            ptr_q   <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            if (win_cmp_c == '0) begin
              state    <= ST_DONE;
              done     <= NUM_REQ'(1) << win_q;
              done_err <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state <= ST_WR_DIS;
              phase <= PH_GAP;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (irq_i[1]) begin
            state <= ST_WR_OFF;
            phase <= PH_GAP;
          end else if (irq_i[0]) begin
            err_q <= 1'b1;
            state <= ST_WR_OFF;
            phase <= PH_GAP;
          end
        end

        ST_DONE: begin
          done     <= '0;
          done_err <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          case (phase)
            PH_GAP: begin
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PADDR   <= APB_ADDR_WIDTH'(xfer_addr_c);
              PWDATA  <= xfer_data_c;
              PWRITE  <= xfer_write_c;
              phase   <= PH_SETUP;
            end
            PH_SETUP: begin
              PENABLE <= 1'b1;
              phase   <= PH_ACCESS;
            end
            PH_ACCESS: begin
              if (PREADY) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                phase   <= PH_GAP;
                if (state == ST_WR_OFF) begin
                  state    <= ST_DONE;
                  done     <= NUM_REQ'(1) << win_q;
                  done_err <= err_q;
                  busy     <= 1'b0;
                end else if (xfer_fail_c) begin
                  err_q <= 1'b1;
                  state <= ST_WR_OFF;
                end else begin
                  state <= xfer_next_c;
                end
              end
            end
            default: phase <= PH_GAP;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched (APB slave model + request driver).
module tb_timer_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 12;
`ifdef TIMER_SCHED_READBACK_EN
  localparam int EN_LAT = 15;
`else
  localparam int EN_LAT = 12;
`endif

  logic              HCLK      = 1'b0;
  logic              HRESETn   = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_cmp  = '0;
  logic [NREQ*3-1:0] req_presc = '0;
  logic [NREQ-1:0]   done;
  logic              done_err;
  logic              busy;
  logic [AW-1:0]     PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE, PSEL, PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [1:0]        irq_i = 2'b00;

  logic        inject_err   = 1'b0;
  logic        prdata_force = 1'b0;
  logic [31:0] cmp_reg      = '0;

  logic [44:0] wlog[$];
  logic [44:0] rlog[$];
  int          psel_cycles = 0;
  int          viol = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        prev_setup = 1'b0, prev_complete = 1'b0, prev_write = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always #5 HCLK = ~HCLK;

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & inject_err & (PADDR == 12'h8);
  assign PRDATA  = prdata_force ? 32'h3 : cmp_reg;

  timer_sched #(
    .NUM_REQ        (NREQ),
    .APB_ADDR_WIDTH (AW)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmp   (req_cmp),
    .req_presc (req_presc),
    .done      (done),
    .done_err  (done_err),
    .busy      (busy),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .irq_i     (irq_i)
  );

  // APB slave: log completed transfers, keep a CMP register for readback
  always @(posedge HCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        wlog.push_back({1'b1, PADDR, PWDATA});
        if (PADDR == 12'h8) cmp_reg <= PWDATA;
      end else begin
        rlog.push_back({1'b0, PADDR, PWDATA});
      end
    end
    if (PSEL) psel_cycles++;
  end

  // APB protocol watcher: stable setup->access, idle gap, zero PWDATA on reads
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      if (PENABLE && !PSEL) viol++;
      if (prev_setup && !(PSEL && PENABLE && PADDR == prev_addr &&
                          PWDATA == prev_wdata && PWRITE == prev_write)) viol++;
      if (prev_complete && PSEL) viol++;
      if (PSEL && !PWRITE && PWDATA != 32'h0) viol++;
    end
    prev_setup    = PSEL && !PENABLE;
    prev_complete = PSEL && PENABLE && PREADY;
    prev_addr     = PADDR;
    prev_wdata    = PWDATA;
    prev_write    = PWRITE;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic set_req(input int idx, input logic [31:0] cmp, input logic [2:0] presc);
    req_cmp[idx*32 +: 32] = cmp;
    req_presc[idx*3 +: 3] = presc;
    req_valid[idx]        = 1'b1;
  endtask

  task automatic wait_ready(output logic [NREQ-1:0] rdy);
    int cyc = 0;
    while (req_ready == '0 && cyc < 50) begin
      @(negedge HCLK);
      cyc++;
    end
    if (req_ready == '0) check_eq("ready_timeout", 64'(req_ready != '0), 64'd1);
    rdy = req_ready;
  endtask

  task automatic wait_writes(input int n, output int cyc);
    cyc = 0;
    while (wlog.size() < n && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
    end
    if (wlog.size() < n) check_eq("writes_timeout", 64'(wlog.size()), 64'(n));
  endtask

  task automatic wait_done(output logic [NREQ-1:0] dv, output logic de, output int cyc);
    cyc = 0;
    while (done == '0 && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
    end
    if (done == '0) check_eq("done_timeout", 64'(done != '0), 64'd1);
    dv = done;
    de = done_err;
  endtask

  // Issue a single request, hold valid through the grant cycle, then drop it
  task automatic issue(input int idx, input logic [31:0] cmp, input logic [2:0] presc,
                       output logic [NREQ-1:0] rdy);
    set_req(idx, cmp, presc);
    wait_ready(rdy);
    tick(1);
    req_valid[idx] = 1'b0;
  endtask

  // Wait for enable write, raise irq, wait for done
  task automatic run_irq(input logic [1:0] irq, output logic [NREQ-1:0] dv, output logic de,
                         output int lat);
    int c;
    wait_writes(4, c);
    irq_i = irq;
    wait_done(dv, de, lat);
    irq_i = 2'b00;
  endtask

  initial begin
    logic [NREQ-1:0] rdy, dv;
    logic            de;
    int              cyc, ps;

    // Reset state
    tick(2);
    check_eq("reset_outputs",
             {req_ready, done, done_err, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
    HRESETn = 1'b0;
    tick(1);

    // Basic request: req0 cmp=2 presc=0
    set_req(0, 32'd2, 3'd0);
    wait_ready(rdy);
    check_eq("t1_ready", rdy, 4'b0001);
    check_eq("t1_busy_grant", busy, 1'b1);
    tick(1);
    req_valid[0] = 1'b0;
    wait_writes(4, cyc);
    check_eq("t1_en_latency", cyc, EN_LAT);
    check_eq("t1_wr_dis", wlog[0], {1'b1, 12'h4, 32'h0});
    check_eq("t1_wr_cmp", wlog[1], {1'b1, 12'h8, 32'h2});
    check_eq("t1_wr_clr", wlog[2], {1'b1, 12'h0, 32'h0});
    check_eq("t1_wr_en",  wlog[3], {1'b1, 12'h4, 32'h1});
    check_eq("t1_busy_wait", busy, 1'b1);
    irq_i = 2'b10;
    wait_done(dv, de, cyc);
    irq_i = 2'b00;
    check_eq("t1_irq_latency", cyc, 4);
    check_eq("t1_done", dv, 4'b0001);
    check_eq("t1_done_err", de, 1'b0);
    check_eq("t1_busy_done", busy, 1'b0);
    check_eq("t1_wr_off", wlog[4], {1'b1, 12'h4, 32'h0});
    check_eq("t1_nwrites", wlog.size(), 5);
    tick(1);
    check_eq("t1_done_pulse", done, 4'b0000);

    // Simultaneous req0/req2 from a fresh pointer
    HRESETn = 1'b1;
    tick(1);
    HRESETn = 1'b0;
    tick(1);
    wlog.delete();
    set_req(0, 32'd10, 3'd3);
    set_req(2, 32'd20, 3'd3);
    wait_ready(rdy);
    check_eq("t2_ready0", rdy, 4'b0001);
    tick(1);
    req_valid[0] = 1'b0;
    run_irq(2'b10, dv, de, cyc);
    check_eq("t2_dis_presc", wlog[0], {1'b1, 12'h4, 32'h18});
    check_eq("t2_cmp0", wlog[1], {1'b1, 12'h8, 32'd10});
    check_eq("t2_en_presc", wlog[3], {1'b1, 12'h4, 32'h19});
    check_eq("t2_done0", dv, 4'b0001);
    wlog.delete();
    tick(1);
    check_eq("t2_idle_gap", req_ready, 4'b0000);
    tick(1);
    check_eq("t2_ready2", req_ready, 4'b0100);
    tick(1);
    req_valid[2] = 1'b0;
    run_irq(2'b10, dv, de, cyc);
    check_eq("t2_cmp2", wlog[1], {1'b1, 12'h8, 32'd20});
    check_eq("t2_done2", dv, 4'b0100);
    tick(1);
    wlog.delete();
    set_req(2, 32'd20, 3'd3);
    set_req(3, 32'd30, 3'd1);
    wait_ready(rdy);
    check_eq("t2_rr_req3", rdy, 4'b1000);
    tick(1);
    req_valid = '0;
    run_irq(2'b10, dv, de, cyc);
    check_eq("t2_en_req3", wlog[3], {1'b1, 12'h4, 32'h9});
    check_eq("t2_done3", dv, 4'b1000);
    tick(1);

    // PSLVERR on the CMP write aborts to CTRL off
    wlog.delete();
    inject_err = 1'b1;
    issue(1, 32'd5, 3'd2, rdy);
    wait_done(dv, de, cyc);
    inject_err = 1'b0;
    check_eq("t3_done", dv, 4'b0010);
    check_eq("t3_done_err", de, 1'b1);
    check_eq("t3_nwrites", wlog.size(), 3);
    check_eq("t3_wr_cmp", wlog[1], {1'b1, 12'h8, 32'd5});
    check_eq("t3_wr_off", wlog[2], {1'b1, 12'h4, 32'h10});
    tick(1);

    // Overflow irq -> error; both irqs -> compare wins
    wlog.delete();
    issue(3, 32'd100, 3'd0, rdy);
    run_irq(2'b01, dv, de, cyc);
    check_eq("t4_ovf_done", dv, 4'b1000);
    check_eq("t4_ovf_err", de, 1'b1);
    check_eq("t4_ovf_off", wlog[4], {1'b1, 12'h4, 32'h0});
    tick(1);
    wlog.delete();
    issue(0, 32'd100, 3'd0, rdy);
    run_irq(2'b11, dv, de, cyc);
    check_eq("t4_both_done", dv, 4'b0001);
    check_eq("t4_both_err", de, 1'b0);
    tick(1);

    // cmp == 0 completes without APB traffic
    ps = psel_cycles;
    issue(1, 32'd0, 3'd5, rdy);
    check_eq("t5_ready", rdy, 4'b0010);
    check_eq("t5_done", done, 4'b0010);
    check_eq("t5_done_err", done_err, 1'b0);
    check_eq("t5_no_psel", psel_cycles - ps, 0);
    tick(1);
    check_eq("t5_done_pulse", done, 4'b0000);

    // Reset during the access phase of the enable write
    wlog.delete();
    issue(2, 32'd7, 3'd1, rdy);
    cyc = 0;
    while (!(PSEL && PENABLE && PADDR == 12'h4 && PWDATA[0]) && cyc < 100) begin
      @(negedge HCLK);
      cyc++;
    end
    check_eq("t6_reached_en_access", {PSEL, PENABLE, PWDATA[0]}, 3'b111);
    HRESETn = 1'b1;
    #1;
    check_eq("t6_reset_drop", {PSEL, PENABLE, busy, done}, 7'd0);
    tick(1);
    HRESETn = 1'b0;
    tick(1);
    wlog.delete();
    set_req(1, 32'd7, 3'd1);
    set_req(3, 32'd8, 3'd1);
    wait_ready(rdy);
    check_eq("t6_ptr_reset", rdy, 4'b0010);
    tick(1);
    req_valid = '0;
    wait_writes(1, cyc);
    check_eq("t6_restart_dis", wlog[0], {1'b1, 12'h4, 32'h8});
    run_irq(2'b10, dv, de, cyc);
    check_eq("t6_done", dv, 4'b0010);
    tick(1);

`ifdef TIMER_SCHED_READBACK_EN
    // Readback mismatch aborts with error
    wlog.delete();
    rlog.delete();
    prdata_force = 1'b1;
    issue(2, 32'd2, 3'd0, rdy);
    wait_done(dv, de, cyc);
    prdata_force = 1'b0;
    check_eq("t7_done_err", de, 1'b1);
    check_eq("t7_nwrites", wlog.size(), 3);
    check_eq("t7_read", rlog[0], {1'b0, 12'h8, 32'h0});
    check_eq("t7_wr_off", wlog[2], {1'b1, 12'h4, 32'h0});
    tick(1);
`endif

    check_eq("apb_protocol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Scheduler that shares the single APB timer peripheral among NUM_REQ delay requesters.
- Accepts one delay request per requester as a compare value plus a 3-bit prescaler.
- Arbitrates round-robin between pending requests.
- Acts as APB master to program TIMER, CMP and CTRL, waits for the compare interrupt, disables the timer and pulses done to the winning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
APB_ADDR_WIDTH, 12, APB address width

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  request pending per requester
req_ready  out  NUM_REQ  one-hot accept; request taken when valid&ready
req_cmp  in  NUM_REQ*32  compare value per requester, slice i = bits [32i+31:32i]
req_presc  in  NUM_REQ*3  prescaler per requester, slice i = bits [3i+2:3i]
done  out  NUM_REQ  one-cycle completion pulse
done_err  out  1  valid with done; 1 = aborted on error
busy  out  1  high from accept until done
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error
irq_i  in  2  timer interrupts: [1] compare reached, [0] overflow

Behaviour:
- Reset while HRESETn=1, asynchronous: all outputs 0, FSM IDLE, RR pointer 0. Any APB transfer in flight is abandoned.
- CTRL word = {26'd0, presc, 2'd0, en}.
- FSM states: IDLE, GRANT, WR_DIS, WR_CMP, [RD_CMP], WR_CLR, WR_EN, WAIT, WR_OFF, DONE.
- IDLE -> GRANT when any req_valid is set.
- GRANT: round-robin winner, searching from the RR pointer.
  - req_ready[winner]=1 for exactly 1 cycle.
  - Latch cmp and presc; pointer <= winner+1 (mod NUM_REQ).
  - If cmp==0: go to DONE, done_err=0, no APB traffic.
  - Otherwise go to WR_DIS.
- Register writes, in order:
  - WR_DIS: CTRL = {presc,en=0}.
  - WR_CMP: CMP = cmp.
  - WR_CLR: TIMER = 0.
  - WR_EN: CTRL = {presc,en=1}.
  - Each state advances on transfer completion.
- APB master handshake:
  - Setup cycle: PSEL=1, PENABLE=0.
  - Access: PENABLE=1, held until PREADY=1; transfer completes that cycle.
  - PADDR/PWDATA/PWRITE are stable across setup and access.
  - Between transfers PSEL=PENABLE=0 for at least 1 cycle.
  - PWDATA=0 on reads.
- PSLVERR=1 on a completing transfer: abort to WR_OFF with error flag set. The WR_OFF write itself ignores PSLVERR.
- WAIT: irq_i sampled each cycle, treated as level.
  - irq_i[1]=1: go to WR_OFF.
  - irq_i[0]=1 and irq_i[1]=0: set error flag, go to WR_OFF.
  - Both set in the same cycle: compare wins, no error.
- WR_OFF: CTRL = {presc,en=0}, then DONE.
- DONE, 1 cycle:
  - done[winner]=1 and done_err=flag; busy drops the same cycle.
  - Go to IDLE; next grant earliest 1 cycle later.
- Requests arriving while busy stay pending (valid held); no preemption.
- req_valid dropping before grant means the request is not served.
- Latency with PREADY=1: accept -> enable = 1 GRANT + 4×(2 + 1 idle) cycles. Irq -> done = 3 cycles (WR_OFF) + 1 (DONE).

Optional Feature:
- Macro: TIMER_SCHED_READBACK_EN.
- Defined: RD_CMP state follows WR_CMP.
  - APB read of CMP.
  - PRDATA != latched cmp, or PSLVERR: set error flag, go to WR_OFF.
  - Otherwise go to WR_CLR.
- Undefined: RD_CMP does not exist; WR_CMP -> WR_CLR directly; PRDATA is unused.

Decomposition:
- Package timer_sched_pkg:
  - Address constants TIMER_ADDR=12'h0, CTRL_ADDR=12'h4, CMP_ADDR=12'h8.
  - CTRL bit positions (EN=0, PRESC=5:3).
  - FSM state enum typedef.
  - Function building the CTRL word.
- One sub-module: timer_sched_rr_arb. Round-robin one-hot arbiter, inputs req and pointer, output grant.

Test Plan:
- Req0 cmp=2, presc=0, PREADY=1:
  - APB writes CTRL=0x0, CMP=0x2, TIMER=0x0, CTRL=0x1.
  - Drive irq_i[1] -> write CTRL=0x0, then done[0]=1, done_err=0.
- Req0 and req2 valid in the same cycle, presc=3:
  - Req0 is served first and CTRL enable writes 0x19.
  - Req2 is granted the cycle after req0's DONE returns the FSM to IDLE.
  - Next simultaneous round: req2 is not favoured over req3.
- PSLVERR on the WR_CMP transfer -> no WR_CLR/WR_EN; CTRL=0x0 written; done with done_err=1.
- irq_i[0] during WAIT -> done_err=1. irq_i=2'b11 -> done_err=0.
- Req1 cmp=0 -> req_ready[1], then done[1] 1 cycle later, no PSEL activity.
- Reset asserted during PENABLE of WR_EN -> PSEL, PENABLE, busy and done drop immediately. After release a new request restarts at WR_DIS.
- With READBACK_EN, PRDATA=0x3 for cmp=0x2 -> error path, done_err=1.
